// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit.
//   master : command issuer / response consumer (drives in_valid, op, a, b, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result, result_hi and status flags)
interface alu_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             sign;
  logic             zero;
  logic             carry;
  logic             parity;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
           sign, zero, carry, parity, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
           sign, zero, carry, parity, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle handshaked ALU: add/sub in one execute cycle, iterative
// shift-add multiply and restoring divide, one command in flight.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_seq_unit_if.slave: valid/ready command (op, a, b) and
//           valid/ready response (result, result_hi, flags)
// Build option: define ALU_MUL_EARLY_EN to let MUL finish as soon as the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a command
// EXEC  | single-cycle add / sub / divide-by-zero
// MUL   | shift-add multiply, one multiplier bit per cycle (LSB first)
// DIV   | restoring divide, one quotient bit per cycle (MSB first)
// DONE  | response held until out_ready
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_mb, r_rem, r_quo;
  logic [CW-1:0]        r_cnt;
  logic                 r_in_ready, r_out_valid;
  logic [WIDTH-1:0]     r_result, r_result_hi;
  logic                 r_sign, r_zero, r_carry, r_parity, r_overflow, r_dbz;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH:0]       w_trial, w_trial_sub;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_next, w_quo_next;
  logic                 w_mul_last;
  logic                 w_fin_done, w_fin_carry, w_fin_ovf, w_fin_dbz, w_fin_zero;
  logic [WIDTH-1:0]     w_fin_res, w_fin_hi;

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff      = r_a - r_b;
  assign w_acc_next  = r_acc + (r_mb[0] ? r_mcand : '0);
  // Partial remainder is always < b, so the shifted trial fits in WIDTH+1 bits.
  assign w_trial     = {r_rem, r_quo[WIDTH-1]};
  assign w_trial_sub = w_trial - {1'b0, r_b};
  assign w_ge        = (w_trial >= {1'b0, r_b});
  assign w_rem_next  = w_ge ? w_trial_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next  = {r_quo[WIDTH-2:0], w_ge};

`ifdef ALU_MUL_EARLY_EN
  assign w_mul_last = (r_mb[WIDTH-1:1] == '0);
`else
  assign w_mul_last = (r_cnt == '0);
`endif

  // Final result/flags for the cycle that moves into DONE.
  always_comb begin
    w_fin_done  = 1'b0;
    w_fin_res   = '0;
    w_fin_hi    = '0;
    w_fin_carry = 1'b0;
    w_fin_ovf   = 1'b0;
    w_fin_dbz   = 1'b0;
    w_fin_zero  = 1'b0;
    case (r_state)
      EXEC: begin
        w_fin_done = 1'b1;
        case (r_op)
          2'b00: begin
            w_fin_res   = w_sum[WIDTH-1:0];
            w_fin_carry = w_sum[WIDTH];
            w_fin_ovf   = (r_a[WIDTH-1] & r_b[WIDTH-1] & ~w_sum[WIDTH-1]) |
                          (~r_a[WIDTH-1] & ~r_b[WIDTH-1] & w_sum[WIDTH-1]);
          end
          2'b01: begin
            w_fin_res   = w_diff;
            w_fin_carry = (r_a < r_b);
            w_fin_ovf   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_diff[WIDTH-1]);
          end
          default: begin
            // Only divide-by-zero reaches EXEC with a non add/sub opcode.
            w_fin_res = '1;
            w_fin_hi  = r_a;
            w_fin_dbz = 1'b1;
          end
        endcase
        w_fin_zero = (w_fin_res == '0);
      end
      MUL: begin
        w_fin_done  = w_mul_last;
        w_fin_res   = w_acc_next[WIDTH-1:0];
        w_fin_hi    = w_acc_next[2*WIDTH-1:WIDTH];
        w_fin_carry = (w_fin_hi != '0);
        w_fin_zero  = (w_acc_next == '0);
      end
      DIV: begin
        w_fin_done = (r_cnt == '0);
        w_fin_res  = w_quo_next;
        w_fin_hi   = w_rem_next;
        w_fin_zero = (w_quo_next == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mb        <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_parity    <= 1'b0;
      r_overflow  <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_op       <= bus.op;
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_acc      <= '0;
            r_mcand    <= {{WIDTH{1'b0}}, bus.a};
            r_mb       <= bus.b;
            r_rem      <= '0;
            r_quo      <= bus.a;
            r_cnt      <= CW'(WIDTH - 1);
            r_in_ready <= 1'b0;
            case (bus.op)
              2'b10:   r_state <= MUL;
              2'b11:   r_state <= (bus.b != '0) ? DIV : EXEC;
              default: r_state <= EXEC;
            endcase
          end
        end
        MUL: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mb    <= r_mb >> 1;
          r_cnt   <= r_cnt - 1'b1;
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: ;
      endcase

      if (w_fin_done) begin
        r_state     <= DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_fin_res;
        r_result_hi <= w_fin_hi;
        r_sign      <= w_fin_res[WIDTH-1];
        r_zero      <= w_fin_zero;
        r_carry     <= w_fin_carry;
        r_parity    <= ~^w_fin_res;
        r_overflow  <= w_fin_ovf;
        r_dbz       <= w_fin_dbz;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.result_hi   = r_result_hi;
  assign bus.sign        = r_sign;
  assign bus.zero        = r_zero;
  assign bus.carry       = r_carry;
  assign bus.parity      = r_parity;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: the driver pushes model results as
// commands are accepted, the monitor pops and compares on each response.
module tb_alu_seq_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(W)) bus();
  alu_seq_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [5:0]   flags;   // {sign, zero, carry, parity, overflow, div_by_zero}
    int           lat;
    int           acc;
    int           stall;
  } exp_t;

  exp_t scb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   in_resp = 0;
  bit   hs_pend = 0;
  int   stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written straight from the arithmetic definitions.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint ua, ub, p, sa, sbv, s, maxs, mins, modv;
    logic [W-1:0] r, hi;
    logic c, ov, dz, z;
    ua = longint'(a); ub = longint'(b);
    modv = longint'(1) << W;
    maxs = (modv / 2) - 1; mins = -(modv / 2);
    sa  = (ua > maxs) ? ua - modv : ua;
    sbv = (ub > maxs) ? ub - modv : ub;
    hi = '0; c = 0; ov = 0; dz = 0;
    r = '0; z = 0;
    e.lat = 1;
    case (op)
      2'd0: begin
        p = ua + ub; r = W'(p); c = (p >= modv);
        s = sa + sbv; ov = (s > maxs) || (s < mins);
        z = (r == 0);
      end
      2'd1: begin
        p = ua - ub; r = W'(p); c = (ua < ub);
        s = sa - sbv; ov = (s > maxs) || (s < mins);
        z = (r == 0);
      end
      2'd2: begin
        p = ua * ub; r = W'(p); hi = W'(p >> W); c = (hi != 0);
        z = (p == 0);
`ifdef ALU_MUL_EARLY_EN
        e.lat = 1;
        for (int i = 0; i < W; i++) if (b[i]) e.lat = i + 1;
`else
        e.lat = W;
`endif
      end
      default: begin
        if (ub == 0) begin
          r = '1; hi = a; dz = 1;
        end else begin
          r = W'(ua / ub); hi = W'(ua % ub); e.lat = W;
        end
        z = (r == 0);
      end
    endcase
    e.res = r;
    e.hi = hi;
    e.flags = {r[W-1], z, c, ~^r, ov, dz};
    e.acc = 0;
    e.stall = 0;
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready never rose, expected acceptance within 300 cycles");
      bus.in_valid = 1'b0;
    end else begin
      e = model(op, a, b);
      e.acc = cyc + 1;
      e.stall = stall;
      scb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 2'($urandom);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((scb.size() != 0 || in_resp) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", scb.size());
    end
  endtask

  // Monitor: compares responses and drives out_ready (with optional stall).
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 0; hs_pend = 0; stall_left = 0;
      bus.out_ready = 1'b0;
    end else if (hs_pend) begin
      hs_pend = 0;
      in_resp = 0;
      check("valid_drop", bus.out_valid, 0);
      bus.out_ready = 1'($urandom_range(0, 1));
    end else if (bus.out_valid) begin
      if (!in_resp) begin
        in_resp = 1;
        if (scb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: result %0h with no command outstanding", bus.result);
          cur.res = bus.result; cur.hi = bus.result_hi; cur.stall = 0;
          cur.flags = {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow, bus.div_by_zero};
        end else begin
          cur = scb.pop_front();
          check("result", bus.result, cur.res);
          check("result_hi", bus.result_hi, cur.hi);
          check("flags", {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow, bus.div_by_zero}, cur.flags);
          check("latency", cyc - cur.acc, cur.lat);
          check("in_ready_busy", bus.in_ready, 0);
        end
        stall_left = cur.stall;
      end else begin
        check("hold_result", {bus.result_hi, bus.result}, {cur.hi, cur.res});
        check("hold_flags", {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow, bus.div_by_zero}, cur.flags);
        check("hold_in_ready", bus.in_ready, 0);
      end
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
      if (bus.out_ready) hs_pend = 1;
    end else begin
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_result", {bus.result_hi, bus.result}, 0);
    check("rst_flags", {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow, bus.div_by_zero}, 0);
    rst_n = 1'b1;

    issue(2'd0, 8'hFF, 8'h01, 0);
    issue(2'd1, 8'h80, 8'h01, 0);
    issue(2'd1, 8'h03, 8'h05, 0);
    issue(2'd2, 8'hFF, 8'hFF, 0);
    issue(2'd2, 8'h0A, 8'h03, 0);
    issue(2'd2, 8'h37, 8'h00, 0);
    issue(3'd3, 8'd100, 8'd7, 0);
    issue(2'd3, 8'h55, 8'h00, 0);
    issue(2'd3, 8'h03, 8'h09, 0);
    issue(2'd0, 8'h7F, 8'h01, 5);   // back-pressure: out_ready low for 5 cycles
    issue(2'd0, 8'h11, 8'h22, 0);   // must wait for the stalled handshake
    drain();

    // Reset during multiply: response must be discarded.
    issue(2'd2, 8'hC3, 8'hA5, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    scb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 8'd2, 8'd3, 0);
    drain();

    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(op, a, b, $urandom_range(0, 3));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
